// File: rtl/rom_sequencer.sv
// Walks a ROM address range and hands each word to the LCD driver over a
// data_ready / lcd_busy handshake, with loop mode, pause, abort and a watchdog.
module rom_sequencer #(
    parameter int ADDR_WIDTH     = 4,
    parameter int START_ADDR     = 0,
    parameter int END_ADDR       = 2**ADDR_WIDTH-1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clock,
    input  logic                  internal_reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  pause,
    input  logic                  loop_mode,
    input  logic                  lcd_busy,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic                  data_ready,
    output logic                  active,
    output logic                  done,
    output logic                  wrapped,
    output logic                  error
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] END_A   = ADDR_WIDTH'(END_ADDR);
    localparam logic [CNT_W-1:0]      TMO_LIM = CNT_W'(TIMEOUT_CYCLES);

    generate
        if (START_ADDR < 0 || START_ADDR > END_ADDR || END_ADDR > 2**ADDR_WIDTH-1
            || TIMEOUT_CYCLES < 0) begin : g_bad_params
            $error("rom_sequencer: need 0 <= START_ADDR <= END_ADDR <= 2**ADDR_WIDTH-1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FREE,
        ST_WAIT_ACCEPT,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    data_ready_q, data_ready_d;
    logic                    active_q, active_d;
    logic                    done_q, done_d;
    logic                    wrapped_q, wrapped_d;
    logic                    error_q, error_d;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        data_ready_d = data_ready_q;
        done_d       = done_q;
        error_d      = error_q;
        wrapped_d    = 1'b0;

        if (abort) begin
            state_d      = ST_IDLE;
            addr_d       = START_A;
            cnt_d        = '0;
            data_ready_d = 1'b0;
            done_d       = 1'b0;
            error_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_d      = ST_WAIT_FREE;
                        addr_d       = START_A;
                        data_ready_d = 1'b0;
                        done_d       = 1'b0;
                        error_d      = 1'b0;
                    end
                end
                ST_WAIT_FREE: begin
                    if (!lcd_busy && !pause) begin
                        state_d      = ST_WAIT_ACCEPT;
                        data_ready_d = 1'b1;
                        cnt_d        = '0;
                    end
                end
                ST_WAIT_ACCEPT: begin
                    if (lcd_busy) begin
                        data_ready_d = 1'b0;
                        if (addr_q != END_A) begin
                            addr_d  = addr_q + ADDR_WIDTH'(1);
                            state_d = ST_WAIT_FREE;
                        end else if (loop_mode) begin
                            addr_d    = START_A;
                            wrapped_d = 1'b1;
                            state_d   = ST_WAIT_FREE;
                        end else begin
                            addr_d  = START_A;
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end else if (TIMEOUT_CYCLES > 0) begin
                        // Failing address is kept on rom_address for diagnosis.
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == TMO_LIM) begin
                            data_ready_d = 1'b0;
                            error_d      = 1'b1;
                            state_d      = ST_ERROR;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        active_d = (state_d == ST_WAIT_FREE) || (state_d == ST_WAIT_ACCEPT);
    end

    always_ff @(posedge clock or negedge internal_reset_n) begin
        if (!internal_reset_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= START_A;
            cnt_q        <= '0;
            data_ready_q <= 1'b0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
            wrapped_q    <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            data_ready_q <= data_ready_d;
            active_q     <= active_d;
            done_q       <= done_d;
            wrapped_q    <= wrapped_d;
            error_q      <= error_d;
        end
    end

    assign rom_address = addr_q;
    assign data_ready  = data_ready_q;
    assign active      = active_q;
    assign done        = done_q;
    assign wrapped     = wrapped_q;
    assign error       = error_q;

endmodule

// File: tb/tb_rom_sequencer.sv
// Directed bench: dut_a is a 16-word one-shot sequencer with an 8-cycle watchdog,
// dut_b a 4..6 looping sequencer with the watchdog disabled.
module tb_rom_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_start = 0, a_abort = 0, a_pause = 0, a_loop = 0, a_busy = 0;
    logic [3:0] a_addr;
    logic       a_dr, a_act, a_done, a_wrap, a_err;

    logic       b_start = 0, b_abort = 0, b_pause = 0, b_loop = 1, b_busy = 0;
    logic [4:0] b_addr;
    logic       b_dr, b_act, b_done, b_wrap, b_err;

    rom_sequencer #(.ADDR_WIDTH(4), .START_ADDR(0), .END_ADDR(15), .TIMEOUT_CYCLES(8)) dut_a (
        .clock(clk), .internal_reset_n(rst_n), .start(a_start), .abort(a_abort),
        .pause(a_pause), .loop_mode(a_loop), .lcd_busy(a_busy), .rom_address(a_addr),
        .data_ready(a_dr), .active(a_act), .done(a_done), .wrapped(a_wrap), .error(a_err));

    rom_sequencer #(.ADDR_WIDTH(5), .START_ADDR(4), .END_ADDR(6), .TIMEOUT_CYCLES(0)) dut_b (
        .clock(clk), .internal_reset_n(rst_n), .start(b_start), .abort(b_abort),
        .pause(b_pause), .loop_mode(b_loop), .lcd_busy(b_busy), .rom_address(b_addr),
        .data_ready(b_dr), .active(b_act), .done(b_done), .wrapped(b_wrap), .error(b_err));

    int checks = 0;
    int failures = 0;

    // flags = {data_ready, active, done, wrapped, error}
    typedef struct {
        logic       start, abort, pause, busy;
        logic [3:0] addr;
        logic [4:0] flags;
    } vec_t;
    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_dr(input bit sel);
        int k;
        k = 0;
        while (!(sel ? b_dr : a_dr) && k < 30) begin
            step();
            k++;
        end
        chk("wait_data_ready_timeout", 32'(k >= 30), 0);
    endtask

    // LCD model: busy for 3 cycles once data_ready is seen.
    task automatic accept_a(input int exp_addr, input int nxt, input bit exp_done);
        wait_dr(0);
        chk("a_present_addr", a_addr, exp_addr);
        a_busy = 1;
        step();
        chk("a_accept_dr", a_dr, 0);
        chk("a_next_addr", a_addr, nxt);
        chk("a_done", a_done, exp_done);
        step();
        step();
        a_busy = 0;
    endtask

    task automatic accept_b(input int exp_addr, input int nxt, input bit exp_wrap);
        wait_dr(1);
        chk("b_present_addr", b_addr, exp_addr);
        b_busy = 1;
        step();
        b_busy = 0;
        chk("b_next_addr", b_addr, nxt);
        chk("b_wrapped", b_wrap, exp_wrap);
        chk("b_done", b_done, 0);
        step();
        chk("b_wrapped_pulse_end", b_wrap, 0);
    endtask

    initial begin
        vecs[0]  = '{1, 0, 0, 0, 4'd0, 5'b01000};  // start -> WAIT_FREE
        vecs[1]  = '{0, 0, 0, 0, 4'd0, 5'b11000};  // present word 0
        vecs[2]  = '{0, 0, 0, 0, 4'd0, 5'b11000};  // held while not busy
        vecs[3]  = '{0, 0, 0, 1, 4'd1, 5'b01000};  // accept -> addr 1
        vecs[4]  = '{0, 0, 0, 1, 4'd1, 5'b01000};  // LCD still busy
        vecs[5]  = '{0, 0, 1, 0, 4'd1, 5'b01000};  // paused
        vecs[6]  = '{0, 0, 0, 0, 4'd1, 5'b11000};  // present word 1
        vecs[7]  = '{0, 0, 1, 0, 4'd1, 5'b11000};  // pause ignored in WAIT_ACCEPT
        vecs[8]  = '{0, 0, 0, 1, 4'd2, 5'b01000};  // accept -> addr 2
        vecs[9]  = '{1, 0, 0, 0, 4'd2, 5'b11000};  // start ignored, present word 2
        vecs[10] = '{1, 1, 0, 1, 4'd0, 5'b00000};  // abort beats start and busy
        vecs[11] = '{0, 0, 0, 0, 4'd0, 5'b00000};  // stays idle

        #12;
        chk("reset_a_addr", a_addr, 0);
        chk("reset_a_flags", {a_dr, a_act, a_done, a_wrap, a_err}, 0);
        chk("reset_b_addr", b_addr, 4);
        chk("reset_b_flags", {b_dr, b_act, b_done, b_wrap, b_err}, 0);
        @(negedge clk);
        rst_n = 1;
        step();

        for (int i = 0; i < 12; i++) begin
            a_start = vecs[i].start;
            a_abort = vecs[i].abort;
            a_pause = vecs[i].pause;
            a_busy  = vecs[i].busy;
            step();
            chk($sformatf("vec%0d_addr", i), a_addr, vecs[i].addr);
            chk($sformatf("vec%0d_flags", i), {a_dr, a_act, a_done, a_wrap, a_err}, vecs[i].flags);
        end
        a_start = 0; a_abort = 0; a_pause = 0; a_busy = 0;

        // Full one-shot pass over 0..15
        a_start = 1;
        step();
        a_start = 0;
        for (int i = 0; i < 16; i++) accept_a(i, (i == 15) ? 0 : i + 1, i == 15);
        step();
        chk("pass_done_held", {a_dr, a_act, a_done, a_err}, 4'b0010);
        chk("pass_addr_home", a_addr, 0);

        // Watchdog: address 2 never accepted
        a_start = 1;
        step();
        a_start = 0;
        chk("restart_clears_done", {a_act, a_done}, 2'b10);
        accept_a(0, 1, 0);
        accept_a(1, 2, 0);
        wait_dr(0);
        for (int i = 0; i < 7; i++) step();
        chk("wdog_before_limit", {a_dr, a_err}, 2'b10);
        step();
        chk("wdog_fired", {a_dr, a_act, a_err}, 3'b001);
        chk("wdog_addr", a_addr, 2);
        step();
        chk("error_sticky", {a_err, a_addr}, {1'b1, 4'd2});
        a_start = 1;
        step();
        a_start = 0;
        chk("restart_clears_error", {a_err, a_act, a_addr}, {1'b0, 1'b1, 4'd0});

        // Pause in WAIT_FREE at address 5
        for (int i = 0; i < 4; i++) accept_a(i, i + 1, 0);
        wait_dr(0);
        a_busy = 1;
        step();
        a_pause = 1;
        step();
        step();
        a_busy = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("paused_hold", {a_dr, a_addr}, {1'b0, 4'd5});
        end
        a_pause = 0;
        step();
        chk("unpause_present", {a_dr, a_addr}, {1'b1, 4'd5});
        accept_a(5, 6, 0);
        accept_a(6, 7, 0);

        // abort + start together in WAIT_ACCEPT at address 7
        wait_dr(0);
        chk("abort_at_addr", a_addr, 7);
        a_abort = 1;
        a_start = 1;
        step();
        a_abort = 0;
        a_start = 0;
        chk("abort_state", {a_dr, a_act, a_done, a_err, a_addr}, 8'h00);
        step();
        chk("abort_stays_idle", {a_dr, a_act}, 0);

        // Async reset while word 9 is presented
        a_start = 1;
        step();
        a_start = 0;
        for (int i = 0; i < 9; i++) accept_a(i, i + 1, 0);
        wait_dr(0);
        chk("pre_reset_addr", a_addr, 9);
        #2;
        rst_n = 0;
        #1;
        chk("async_reset", {a_dr, a_act, a_done, a_err, a_addr}, 8'h00);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 5; i++) step();
        chk("post_reset_idle", {a_dr, a_act, a_addr}, 0);

        // Looping range 4..6 on dut_b
        b_start = 1;
        step();
        b_start = 0;
        accept_b(4, 5, 0);
        accept_b(5, 6, 0);
        accept_b(6, 4, 1);
        accept_b(4, 5, 0);
        accept_b(5, 6, 0);
        accept_b(6, 4, 1);
        wait_dr(1);
        for (int i = 0; i < 20; i++) step();
        chk("b_no_watchdog", {b_dr, b_err, b_act}, 3'b101);
        b_abort = 1;
        step();
        b_abort = 0;
        chk("b_abort", {b_dr, b_act, b_addr}, {1'b0, 1'b0, 5'd4});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_sequencer.md
Name: rom_sequencer

Overview:
Parametrised successor to the single-pass ROM-to-LCD controller. It walks a ROM address range from START_ADDR to END_ADDR and presents each word to the LCD driver through a data_ready / lcd_busy handshake. Compared with the previous controller it adds a configurable address width and range, one-shot or loop mode, an explicit start/abort, pause, an accept-timeout watchdog and status outputs. It sits between the character ROM and the LCD driver module.

Parameters:
ADDR_WIDTH, 4, width of rom_address.
START_ADDR, 0, first ROM address of the sequence.
END_ADDR, 2**ADDR_WIDTH-1, last ROM address of the sequence (inclusive).
TIMEOUT_CYCLES, 0, maximum number of cycles data_ready may stay high without the LCD going busy; 0 disables the watchdog.

Ports:
clock  input  1  system clock, rising edge.
internal_reset_n  input  1  asynchronous, active-low reset.
start  input  1  begin a sequence; accepted in IDLE, DONE or ERROR.
abort  input  1  return to IDLE from any state.
pause  input  1  hold off presenting the next word.
loop_mode  input  1  1: wrap END_ADDR->START_ADDR forever; 0: one pass.
lcd_busy  input  1  LCD driver busy flag.
rom_address  output  ADDR_WIDTH  current ROM address.
data_ready  output  1  ROM word at rom_address is valid for the LCD.
active  output  1  sequencer is in WAIT_FREE or WAIT_ACCEPT.
done  output  1  one-shot pass completed (level, held until start, abort or reset).
wrapped  output  1  one-cycle pulse when loop mode wraps.
error  output  1  watchdog expired (sticky until start, abort or reset).

Behaviour:
- All outputs are registered. Asynchronous reset (internal_reset_n=0) sets rom_address=START_ADDR and data_ready, active, done, wrapped and error to 0, state=IDLE, timeout counter=0.
- Elaboration fails unless START_ADDR <= END_ADDR <= 2**ADDR_WIDTH-1.
- States: IDLE, WAIT_FREE, WAIT_ACCEPT, DONE, ERROR.
- IDLE: on start=1, load rom_address=START_ADDR, clear done and error, go to WAIT_FREE.
- WAIT_FREE: if lcd_busy=0 and pause=0, set data_ready=1, clear the timeout counter and go to WAIT_ACCEPT. Otherwise stay.
- WAIT_ACCEPT: data_ready is held at 1 and rom_address is stable. When lcd_busy=1 is sampled, set data_ready=0, then:
  - If rom_address != END_ADDR: rom_address+1, go to WAIT_FREE.
  - If rom_address = END_ADDR and loop_mode=1: rom_address=START_ADDR, pulse wrapped, go to WAIT_FREE.
  - If rom_address = END_ADDR and loop_mode=0: set done=1, rom_address=START_ADDR, go to DONE.
- pause does not affect WAIT_ACCEPT. A word already presented is never withdrawn.
- Watchdog (TIMEOUT_CYCLES>0): the counter increments on each WAIT_ACCEPT cycle with lcd_busy=0. When it reaches TIMEOUT_CYCLES: data_ready=0, error=1, go to ERROR. rom_address keeps the failing address.
- DONE / ERROR: outputs hold. start restarts exactly as from IDLE.
- Priority: abort > start > handshake.
  - abort=1 in any state: go to IDLE, data_ready=0, rom_address=START_ADDR, clear done and error.
  - start is ignored in WAIT_FREE and WAIT_ACCEPT.
- Latency: start sampled at edge 0, lcd_busy=0 → data_ready=1 after edge 1. lcd_busy=1 sampled at edge N → data_ready=0 and the new address after edge N.
- lcd_busy is assumed synchronous to clock. Busy edges are not counted; only levels in the current state are used, so a busy glitch during WAIT_FREE has no effect.
- Single-entry range (START_ADDR=END_ADDR) is legal:
  - loop_mode=1: wrapped pulses after every accept.
  - loop_mode=0: DONE after one word.
- Reset asserted mid-sequence immediately forces reset values. On deassert, the sequencer waits in IDLE for start.

Test Plan:
- Defaults, loop_mode=0, start pulse, LCD model busy for 3 cycles after each data_ready → addresses 0..15 are each presented once. done=1 after the 16th accept, rom_address=0, data_ready=0.
- ADDR_WIDTH=5, START_ADDR=4, END_ADDR=6, loop_mode=1 → address sequence 4,5,6,4,5,6… with wrapped=1 for one cycle on each 6→4 transition. done stays 0.
- TIMEOUT_CYCLES=8, LCD holds lcd_busy=0 after address 2 is presented → after 8 cycles error=1, data_ready=0, rom_address=2. A later start restarts at 0 with error cleared.
- pause=1 asserted while in WAIT_FREE at address 5 for 10 cycles → data_ready stays 0 and rom_address=5. After pause drops, data_ready=1 on the next edge.
- abort and start both high while in WAIT_ACCEPT at address 7 → next cycle state is IDLE, data_ready=0, rom_address=0, active=0.
- internal_reset_n pulsed low mid-accept at address 9 → outputs take reset values asynchronously. After release there is no activity until start.
